fb_scanout: RTL and testbench

Frame-buffer sink and raster reader for the 2D line engine. It owns a DIM×DIM 1-bit bitmap and accepts single-pixel writes from the rasterizer over a valid/ready port. On command it clears the bitmap row by row, or streams it out one row per handshake beat. It sits between the line rasterizer (pixel producer) and the downstream display/serializer (row consumer).

---
 rtl/fb_scanout.sv | 159 +++++++++++++++
 tb/tb_fb_scanout.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// DIM x DIM 1-bit frame buffer: single-pixel writes, row-by-row clear and row scan-out.
// Optional FB_DIRTY_SKIP_EN: scans emit only rows written since the last clear.
module fb_scanout #(
  parameter int unsigned DIM = 64,
  parameter int unsigned AW  = $clog2(DIM)
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           wr_valid,
  input  logic [AW-1:0]  wr_x,
  input  logic [AW-1:0]  wr_y,
  output logic           wr_ready,
  input  logic           clr_start,
  input  logic           scan_start,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DIM-1:0] out_row,
  output logic [AW-1:0]  out_idx,
  output logic           out_last,
  output logic           busy,
  output logic           scan_done
);

  typedef enum logic [1:0] {StIdle, StClear, StScan, StDone} state_e;

  localparam logic [AW-1:0] LastRow = AW'(DIM - 1);

  state_e         state_q;
  logic [AW-1:0]  r_q;
  logic [DIM-1:0] picture_q [DIM];
  logic           out_valid_q, out_last_q, busy_q, scan_done_q;

  logic           wr_fire, beat_fire;
  logic [AW-1:0]  first_row, next_row;
  logic           first_last, next_last, any_rows;

  assign wr_ready  = (state_q == StIdle) & ~clr_start & ~scan_start;
  assign wr_fire   = wr_valid & wr_ready;
  assign beat_fire = out_valid_q & out_ready;

`ifdef FB_DIRTY_SKIP_EN
  logic [DIM-1:0] dirty_q;
  logic [AW-1:0]  last_row;

  // Lowest dirty row, lowest dirty row above r, and highest dirty row.
  always_comb begin
    first_row = '0;
    next_row  = '0;
    last_row  = '0;
    any_rows  = 1'b0;
    for (int i = DIM - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        first_row = AW'(i);
        any_rows  = 1'b1;
      end
      if (dirty_q[i] && (AW'(i) > r_q)) next_row = AW'(i);
    end
    for (int i = 0; i < DIM; i++) begin
      if (dirty_q[i]) last_row = AW'(i);
    end
  end

  assign first_last = (first_row == last_row);
  assign next_last  = (next_row == last_row);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dirty_q <= '0;
    end else if (state_q == StClear) begin
      dirty_q[r_q] <= 1'b0;
    end else if (wr_fire) begin
      dirty_q[wr_y] <= 1'b1;
    end
  end
`else
  assign first_row  = '0;
  assign next_row   = r_q + 1'b1;
  assign any_rows   = 1'b1;
  assign first_last = 1'b0;
  assign next_last  = (next_row == LastRow);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DIM; i++) picture_q[i] <= '0;
    end else if (state_q == StClear) begin
      picture_q[r_q] <= '0;
    end else if (wr_fire) begin
      picture_q[wr_y][wr_x] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q <= StClear;
            r_q     <= '0;
            busy_q  <= 1'b1;
          end else if (scan_start) begin
            busy_q <= 1'b1;
            if (any_rows) begin
              state_q     <= StScan;
              r_q         <= first_row;
              out_valid_q <= 1'b1;
              out_last_q  <= first_last;
            end else begin
              // Nothing to emit: report completion straight away.
              state_q     <= StDone;
              scan_done_q <= 1'b1;
            end
          end
        end
        StClear: begin
          r_q <= r_q + 1'b1;
          if (r_q == LastRow) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StScan: begin
          if (beat_fire) begin
            if (out_last_q) begin
              state_q     <= StDone;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              scan_done_q <= 1'b1;
            end else begin
              r_q        <= next_row;
              out_last_q <= next_last;
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          scan_done_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = r_q;
  assign out_row   = out_valid_q ? picture_q[r_q] : '0;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: random writes and backpressure checked against a
// bitmap-plus-row-list model; works with or without FB_DIRTY_SKIP_EN.
module tb_fb_scanout;
  localparam int DIM = 64;
  localparam int AW  = $clog2(DIM);

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           wr_valid = 1'b0;
  logic [AW-1:0]  wr_x = '0;
  logic [AW-1:0]  wr_y = '0;
  logic           wr_ready;
  logic           clr_start = 1'b0;
  logic           scan_start = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [DIM-1:0] out_row;
  logic [AW-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic           scan_done;

  always #5 clk = ~clk;

  fb_scanout #(.DIM(DIM)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .wr_valid  (wr_valid),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_ready  (wr_ready),
    .clr_start (clr_start),
    .scan_start(scan_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .scan_done (scan_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: the bitmap, which rows hold pixels, and the row list a scan should emit.
  logic [DIM-1:0] model [DIM];
  bit             mdirty [DIM];
  int             exp_rows [$];

  task automatic model_clear();
    for (int i = 0; i < DIM; i++) begin
      model[i]  = '0;
      mdirty[i] = 1'b0;
    end
  endtask

  task automatic build_exp();
    exp_rows.delete();
    for (int i = 0; i < DIM; i++) begin
`ifdef FB_DIRTY_SKIP_EN
      if (mdirty[i]) exp_rows.push_back(i);
`else
      exp_rows.push_back(i);
`endif
    end
  endtask

  task automatic write_pixel(input int x, input int y);
    wr_valid = 1'b1;
    wr_x     = AW'(x);
    wr_y     = AW'(y);
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL write_ready (%0d,%0d) got %b want 1", x, y, wr_ready);
    else n_pass++;
    @(negedge clk);
    wr_valid     = 1'b0;
    model[y][x]  = 1'b1;
    mdirty[y]    = 1'b1;
  endtask

  // Called at a negedge in IDLE. stall_idx forces three stalls on that row.
  task automatic do_scan(input int pct, input int stall_idx, output int cycles);
    int n, b, cyc, stalls, r;
    logic rdy;
    logic [AW+DIM+1:0] got, expv;
    build_exp();
    n = exp_rows.size();
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    b = 0; cyc = 0; stalls = 0;
    while (b < n && cyc < 4 * DIM + 100) begin
      r = exp_rows[b];
      if (r == stall_idx && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end else if (pct > 0) begin
        rdy = ($urandom_range(0, 99) >= pct);
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      expv = {1'b1, AW'(r), model[r], (b == n - 1)};
      got  = {out_valid, out_idx, out_row, out_last};
      n_checks++;
      if (got !== expv) $display("FAIL beat %0d got %h want %h", b, got, expv);
      else n_pass++;
      @(negedge clk);
      cyc++;
      if (rdy) b++;
    end
    if (b < n) begin
      n_checks++;
      $display("FAIL scan_timeout beats %0d want %0d", b, n);
    end
    cycles = cyc;
    n_checks++;
    if ({out_valid, scan_done, busy} !== 3'b011)
      $display("FAIL done_pulse got %b want 011", {out_valid, scan_done, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, scan_done, busy} !== 3'b000)
      $display("FAIL back_idle got %b want 000", {out_valid, scan_done, busy});
    else n_pass++;
    out_ready = 1'b1;
  endtask

  // Called at a negedge in IDLE; returns how many cycles busy stayed high.
  task automatic do_clear(input bit with_write, output int bc);
    clr_start = 1'b1;
    if (with_write) begin
      wr_valid = 1'b1;
      wr_x     = AW'(1);
      wr_y     = AW'(1);
      #1;
      n_checks++;
      if (wr_ready !== 1'b0) $display("FAIL clr_wr_ready got %b want 0", wr_ready);
      else n_pass++;
    end
    @(negedge clk);
    clr_start = 1'b0;
    wr_valid  = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 4 * DIM) begin
      bc++;
      @(negedge clk);
    end
    model_clear();
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({out_valid, out_last, out_row, out_idx, busy, scan_done} !== '0)
      $display("FAIL reset_outputs got v=%b l=%b row=%h idx=%0d busy=%b done=%b want all 0",
               out_valid, out_last, out_row, out_idx, busy, scan_done);
    else n_pass++;
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", wr_ready);
    else n_pass++;
    model_clear();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty_scan();
    int c;
    do_scan(0, -1, c);
    n_checks++;
    if (c !== exp_rows.size()) $display("FAIL empty_scan_cycles got %0d want %0d", c, exp_rows.size());
    else n_pass++;
  endtask

  task automatic test_two_pixels();
    int c;
    write_pixel(3, 5);
    write_pixel(63, 0);
    do_scan(0, -1, c);
  endtask

  task automatic test_backpressure();
    int c;
    write_pixel(int'($urandom_range(0, DIM - 1)), 10);
    do_scan(0, 10, c);
    n_checks++;
    if (c !== exp_rows.size() + 3) $display("FAIL stall_cycles got %0d want %0d", c, exp_rows.size() + 3);
    else n_pass++;
  endtask

  task automatic test_clear_drop();
    int bc, c;
    do_clear(1'b1, bc);
    n_checks++;
    if (bc !== DIM) $display("FAIL clear_busy_cycles got %0d want %0d", bc, DIM);
    else n_pass++;
    do_scan(0, -1, c);
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 30; i++)
      write_pixel(int'($urandom_range(0, DIM - 1)), int'($urandom_range(0, DIM - 1)));
    do_scan(30, -1, c);
  endtask

  task automatic test_dirty_rows();
    int bc, c;
    do_clear(1'b0, bc);
    write_pixel(int'($urandom_range(0, DIM - 1)), 7);
    write_pixel(int'($urandom_range(0, DIM - 1)), 40);
    do_scan(0, -1, c);
    do_clear(1'b0, bc);
    do_scan(0, -1, c);
  endtask

  task automatic test_reset_mid_scan();
    int g, c;
    write_pixel(int'($urandom_range(0, DIM - 1)), 20);
    out_ready  = 1'b1;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    g = 0;
    while (out_idx !== AW'(20) && g < 4 * DIM) begin
      g++;
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL mid_scan_reach got %b want 1", out_valid);
    else n_pass++;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL async_abort got %b want 00", {out_valid, busy});
    else n_pass++;
    model_clear();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL post_reset_wr_ready got %b want 1", wr_ready);
    else n_pass++;
    do_scan(0, -1, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_scan();
    test_two_pixels();
    test_backpressure();
    test_clear_drop();
    test_random();
    test_dirty_rows();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
